// File: rtl/mux_rr_n.sv
// N-channel registered multiplexer with per-channel valid/ready handshakes.
// Selects by manual index or by round-robin; the output word is held stable under backpressure.
module mux_rr_n #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            load_en;
    logic            gnt_vld;
    logic [SELW-1:0] gnt;
    logic [W-1:0]    gnt_data;

    assign load_en = !out_valid_q || out_ready;

    // Only in-range channels are ever compared, so sel >= N simply finds no match.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (!gnt_vld && sel == SELW'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = SELW'(i);
                end
            end
        end else begin
            // Two passes give the wrap-around order: ptr..N-1 first, then 0..ptr-1.
            for (int i = 0; i < N; i++) begin
                if (!gnt_vld && in_valid[i] && SELW'(i) >= ptr_q) begin
                    gnt_vld = 1'b1;
                    gnt     = SELW'(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!gnt_vld && in_valid[i] && SELW'(i) < ptr_q) begin
                    gnt_vld = 1'b1;
                    gnt     = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SELW'(i)) gnt_data = in_data[i*W +: W];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !rst && load_en && gnt_vld && (gnt == SELW'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (gnt_vld) begin
                out_data_d  = gnt_data;
                out_ch_d    = gnt;
                out_valid_d = 1'b1;
                if (mode) ptr_d = (gnt == SELW'(N-1)) ? '0 : gnt + 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: a 4-channel instance for most scenarios and a
// 3-channel instance for the out-of-range select case.
module tb_mux_rr_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic        mode4, out_valid4, out_ready4;
    logic [1:0]  sel4, out_ch4;
    logic [7:0]  out_data4;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3, out_valid3, out_ready3;
    logic [1:0]  sel3, out_ch3;
    logic [7:0]  out_data3;

    int total = 0;
    int bad   = 0;

    mux_rr_n #(.N(4), .W(8), .SELW(2)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode4), .sel(sel4), .out_data(out_data4), .out_ch(out_ch4),
        .out_valid(out_valid4), .out_ready(out_ready4)
    );

    mux_rr_n #(.N(3), .W(8), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3), .out_data(out_data3), .out_ch(out_ch3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    // Inputs change on the falling edge; registered outputs are read on the
    // falling edge, combinational in_ready 1ns after driving.
    task automatic test_reset();
        rst = 1'b1; mode4 = 1'b0; sel4 = 2'd0; in_valid4 = 4'b1111; out_ready4 = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL rst_in_ready: got %b want 0000", in_ready4); end
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid4); end
        total++; if (out_data4 !== 8'h00) begin bad++; $display("FAIL rst_out_data: got %h want 00", out_data4); end
        total++; if (out_ch4 !== 2'd0) begin bad++; $display("FAIL rst_out_ch: got %0d want 0", out_ch4); end
        total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL rst_out_valid3: got %b want 0", out_valid3); end
        in_valid4 = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_manual();
        mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b1111; out_ready4 = 1'b1;
        in_data4 = {8'h44, 8'hA5, 8'h22, 8'h11};
        #1;
        total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL man_in_ready: got %b want 0100", in_ready4); end
        @(negedge clk);
        total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL man_out_valid: got %b want 1", out_valid4); end
        total++; if (out_data4 !== 8'hA5) begin bad++; $display("FAIL man_out_data: got %h want a5", out_data4); end
        total++; if (out_ch4 !== 2'd2) begin bad++; $display("FAIL man_out_ch: got %0d want 2", out_ch4); end
        in_valid4 = 4'b0000;
        @(negedge clk);
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL idle_out_valid: got %b want 0", out_valid4); end
        total++; if (out_data4 !== 8'hA5) begin bad++; $display("FAIL idle_hold_data: got %h want a5", out_data4); end
    endtask

    task automatic test_rr_fair();
        logic [3:0] exp_rdy;
        logic [1:0] exp_ch;
        mode4 = 1'b1; in_valid4 = 4'b1111; out_ready4 = 1'b1;
        in_data4 = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 6; k++) begin
            exp_ch  = 2'(k % 4);
            exp_rdy = 4'b0001 << exp_ch;
            #1;
            total++; if (in_ready4 !== exp_rdy) begin bad++; $display("FAIL rr_in_ready[%0d]: got %b want %b", k, in_ready4, exp_rdy); end
            @(negedge clk);
            total++; if (out_valid4 !== 1'b1 || out_ch4 !== exp_ch || out_data4 !== (8'h10 + 8'(exp_ch))) begin
                bad++; $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                                k, out_valid4, out_ch4, out_data4, exp_ch, 8'h10 + 8'(exp_ch));
            end
        end
        in_valid4 = 4'b0000;
        @(negedge clk);
    endtask

    // Pointer enters at 2; ch2 grant moves it to 3 before the skip/wrap vectors.
    task automatic test_rr_skip_wrap();
        mode4 = 1'b1; out_ready4 = 1'b1; in_data4 = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        in_valid4 = 4'b0100;
        @(negedge clk);
        in_valid4 = 4'b0010;
        #1;
        total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL skip_in_ready: got %b want 0010", in_ready4); end
        @(negedge clk);
        total++; if (out_ch4 !== 2'd1 || out_data4 !== 8'hD1) begin bad++; $display("FAIL skip_out: got ch=%0d d=%h want ch=1 d=d1", out_ch4, out_data4); end
        in_valid4 = 4'b0001;
        #1;
        total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL wrap_in_ready: got %b want 0001", in_ready4); end
        @(negedge clk);
        total++; if (out_ch4 !== 2'd0 || out_data4 !== 8'hD0) begin bad++; $display("FAIL wrap_out: got ch=%0d d=%h want ch=0 d=d0", out_ch4, out_data4); end
        in_valid4 = 4'b1111;
        #1;
        total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL wrap_ptr1: got %b want 0010", in_ready4); end
        @(negedge clk);
        in_valid4 = 4'b0000;
        @(negedge clk);
    endtask

    // Pointer enters at 2 and must survive the stall untouched.
    task automatic test_backpressure();
        logic [3:0] pat [3];
        pat[0] = 4'b1111; pat[1] = 4'b0101; pat[2] = 4'b1000;
        mode4 = 1'b0; sel4 = 2'd1; in_valid4 = 4'b0010; out_ready4 = 1'b1;
        in_data4 = {8'hC3, 8'hC2, 8'h3C, 8'hC0};
        @(negedge clk);
        total++; if (out_valid4 !== 1'b1 || out_data4 !== 8'h3C) begin bad++; $display("FAIL bp_load: got v=%b d=%h want v=1 d=3c", out_valid4, out_data4); end
        out_ready4 = 1'b0; mode4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid4 = pat[k];
            in_data4  = {8'hC3, 8'hC2, 8'h50 + 8'(k), 8'hC0};
            #1;
            total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", k, in_ready4); end
            @(negedge clk);
            total++; if (out_valid4 !== 1'b1 || out_data4 !== 8'h3C || out_ch4 !== 2'd1) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=1 d=3c", k, out_valid4, out_ch4, out_data4);
            end
        end
        out_ready4 = 1'b1; in_valid4 = 4'b1111;
        #1;
        total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL bp_release_rdy: got %b want 0100", in_ready4); end
        @(negedge clk);
        total++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd2 || out_data4 !== 8'hC2) begin
            bad++; $display("FAIL bp_release_out: got v=%b ch=%0d d=%h want v=1 ch=2 d=c2", out_valid4, out_ch4, out_data4);
        end
        in_valid4 = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {8'h79, 8'h78, 8'h77};
        @(negedge clk);
        total++; if (out_valid3 !== 1'b1 || out_data3 !== 8'h77) begin bad++; $display("FAIL oor_load: got v=%b d=%h want v=1 d=77", out_valid3, out_data3); end
        sel3 = 2'd3;
        #1;
        total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL oor_in_ready: got %b want 000", in_ready3); end
        @(negedge clk);
        total++; if (out_valid3 !== 1'b0 || out_data3 !== 8'h77 || out_ch3 !== 2'd0) begin
            bad++; $display("FAIL oor_drain: got v=%b ch=%0d d=%h want v=0 ch=0 d=77", out_valid3, out_ch3, out_data3);
        end
        sel3 = 2'd2;
        #1;
        total++; if (in_ready3 !== 3'b100) begin bad++; $display("FAIL oor_top_ch: got %b want 100", in_ready3); end
        @(negedge clk);
        total++; if (out_ch3 !== 2'd2 || out_data3 !== 8'h79) begin bad++; $display("FAIL oor_top_out: got ch=%0d d=%h want ch=2 d=79", out_ch3, out_data3); end
        in_valid3 = 3'b000;
        @(negedge clk);
    endtask

    // Pointer enters at 3: ch3 then ch1 leaves it at 2 with a word held.
    task automatic test_reset_mid();
        mode4 = 1'b1; out_ready4 = 1'b1; in_data4 = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        in_valid4 = 4'b1000;
        @(negedge clk);
        in_valid4 = 4'b0010;
        @(negedge clk);
        total++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd1) begin bad++; $display("FAIL mid_setup: got v=%b ch=%0d want v=1 ch=1", out_valid4, out_ch4); end
        out_ready4 = 1'b0; in_valid4 = 4'b1111; rst = 1'b1;
        #1;
        total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL mid_rst_rdy: got %b want 0000", in_ready4); end
        @(negedge clk);
        total++; if (out_valid4 !== 1'b0 || out_data4 !== 8'h00 || out_ch4 !== 2'd0) begin
            bad++; $display("FAIL mid_rst_out: got v=%b ch=%0d d=%h want v=0 ch=0 d=00", out_valid4, out_ch4, out_data4);
        end
        rst = 1'b0; out_ready4 = 1'b1;
        #1;
        total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL mid_ptr0_rdy: got %b want 0001", in_ready4); end
        @(negedge clk);
        total++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd0 || out_data4 !== 8'hE0) begin
            bad++; $display("FAIL mid_ptr0_out: got v=%b ch=%0d d=%h want v=1 ch=0 d=e0", out_valid4, out_ch4, out_data4);
        end
        in_valid4 = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_data4 = '0; in_valid4 = '0; mode4 = 1'b0; sel4 = '0; out_ready4 = 1'b1;
        in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
        test_reset();
        test_manual();
        test_rr_fair();
        test_rr_skip_wrap();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
